bsg_activation_inverse: RTL and testbench

BSG_ACTIVATION_INVERSE -- requirements
Module: bsg_activation_inverse

---
 rtl/bsg_activation_inverse_if.sv | 24 ++
 rtl/bsg_activation_inverse.sv | 192 +++++++++++++++++++
 tb/tb_bsg_activation_inverse.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_activation_inverse_if.sv
// Handshake bundle for bsg_activation_inverse: input channel plus result channel.
// An input moves on a rising edge where v_i && ready_and_o; a result leaves when yumi_i is asserted while v_o is high.
interface bsg_activation_inverse_if #(
    parameter int ans_width_p = 32,
    parameter int ang_width_p = 21
);
    logic                   v_i;
    logic [ans_width_p-1:0] data_i;
    logic                   tanh_sel_i;
    logic                   ready_and_o;
    logic                   v_o;
    logic [ang_width_p-1:0] ang_o;
    logic                   yumi_i;

    modport master (
        output v_i, data_i, tanh_sel_i, yumi_i,
        input  ready_and_o, v_o, ang_o
    );

    modport slave (
        input  v_i, data_i, tanh_sel_i, yumi_i,
        output ready_and_o, v_o, ang_o
    );
endinterface

// File: rtl/bsg_activation_inverse.sv
// Inverse activation: atanh(t) by iterative hyperbolic CORDIC vectoring, with saturation and small-input bypasses.
// Define BSG_ACTIVATION_INVERSE_LOGIT_EN to add logit(p) = 2*atanh(2p-1), selected by tanh_sel_i.
module bsg_activation_inverse #(
    parameter int         ans_width_p   = 32,
    parameter int         ang_width_p   = 21,
    parameter int         precision_p   = 16,
    parameter logic [7:0] thresh_p      = 8'b00001100,
    parameter int         zero_thresh_p = 'h14
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    bsg_activation_inverse_if.slave   io,
    output logic [2:0]                state_o
);

    localparam int W       = ans_width_p + 2;
    localparam int G_RAW   = W - precision_p - 6;
    // Guard bits below the binary point of x/y keep shift truncation out of the result.
    localparam int G       = (G_RAW > 0) ? G_RAW : 0;
    localparam int LUT_SHL = (precision_p >= 16) ? precision_p - 16 : 0;
    localparam int LUT_SHR = (precision_p < 16) ? 16 - precision_p : 0;

    localparam logic signed [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1} << precision_p;
    localparam logic signed [W-1:0] THRESH  = {{(W-8){1'b0}}, thresh_p} << (precision_p - 4);
    localparam logic signed [W-1:0] ZTHRESH = W'(zero_thresh_p);
    localparam logic [4:0]          ITER_LAST = 5'd17;

    localparam logic signed [ang_width_p-1:0] ANG_MAX = {1'b0, {(ang_width_p-1){1'b1}}};
    localparam logic signed [ang_width_p-1:0] ANG_MIN = {1'b1, {(ang_width_p-2){1'b0}}, 1'b1};
    localparam logic signed [W:0]             R_MAX   = {{(W+2-ang_width_p){1'b0}}, {(ang_width_p-1){1'b1}}};
    localparam logic signed [W:0]             R_MIN   = -R_MAX;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_POST, S_DONE} state_e;

    state_e                 state_r, state_nxt;
    logic [ans_width_p-1:0] data_r;
    logic                   neg_r, sat_r;
    logic signed [W-1:0]    x_r, y_r, z_r;
    logic [4:0]             cnt_r;
    logic [ang_width_p-1:0] ang_r;
    logic                   accept;

    logic signed [W-1:0]    data_ext, u, u_abs;
    logic                   sat, zero;
    logic [4:0]             sh;
    logic signed [W-1:0]    xs, ys, at, x_nxt, y_nxt, z_nxt;
    logic signed [W:0]      r_mag, r_sgn;
    logic [ang_width_p-1:0] ang_nxt;

`ifdef BSG_ACTIVATION_INVERSE_LOGIT_EN
    logic sel_r;
`else
    logic unused_tanh_sel;
    assign unused_tanh_sel = io.tanh_sel_i;
`endif

    // atanh(2^-i) rounded to Q16, rescaled to the working precision.
    function automatic logic signed [W-1:0] atanh_lut(input logic [4:0] i);
        logic [W-1:0] q16;
        case (i)
            5'd1:    q16 = W'(35999);
            5'd2:    q16 = W'(16739);
            5'd3:    q16 = W'(8235);
            5'd4:    q16 = W'(4101);
            5'd5:    q16 = W'(2049);
            5'd6:    q16 = W'(1024);
            5'd7:    q16 = W'(512);
            5'd8:    q16 = W'(256);
            5'd9:    q16 = W'(128);
            5'd10:   q16 = W'(64);
            5'd11:   q16 = W'(32);
            5'd12:   q16 = W'(16);
            5'd13:   q16 = W'(8);
            5'd14:   q16 = W'(4);
            5'd15:   q16 = W'(2);
            5'd16:   q16 = W'(1);
            default: q16 = '0;
        endcase
        return $signed((q16 << LUT_SHL) >> LUT_SHR);
    endfunction

    // Step k -> shift i; steps 4 and 14 repeat shifts 4 and 13.
    function automatic logic [4:0] shift_of(input logic [4:0] k);
        if (k < 5'd4)       return k + 5'd1;
        else if (k < 5'd14) return k;
        else                return k - 5'd1;
    endfunction

    assign io.ready_and_o = (state_r == S_IDLE) & reset_n_i;
    assign io.v_o         = (state_r == S_DONE);
    assign io.ang_o       = ang_r;
    assign state_o        = state_r;
    assign accept         = io.v_i & io.ready_and_o;

    always_comb begin
        data_ext = {{2{data_r[ans_width_p-1]}}, data_r};
`ifdef BSG_ACTIVATION_INVERSE_LOGIT_EN
        u = sel_r ? data_ext : ((data_ext <<< 1) - ONE);
`else
        u = data_ext;
`endif
        u_abs = u[W-1] ? -u : u;
        sat   = (u_abs > THRESH);
        zero  = !sat && (u_abs < ZTHRESH);

        sh    = shift_of(cnt_r);
        xs    = x_r >>> sh;
        ys    = y_r >>> sh;
        at    = atanh_lut(sh);
        if (!y_r[W-1]) begin
            x_nxt = x_r - ys;
            y_nxt = y_r - xs;
            z_nxt = z_r + at;
        end else begin
            x_nxt = x_r + ys;
            y_nxt = y_r + xs;
            z_nxt = z_r - at;
        end

        r_mag = {z_r[W-1], z_r};
`ifdef BSG_ACTIVATION_INVERSE_LOGIT_EN
        if (!sel_r) r_mag = r_mag <<< 1;
`endif
        r_sgn = neg_r ? -r_mag : r_mag;
        if (sat_r)              ang_nxt = neg_r ? ANG_MIN : ANG_MAX;
        else if (r_sgn > R_MAX) ang_nxt = ANG_MAX;
        else if (r_sgn < R_MIN) ang_nxt = ANG_MIN;
        else                    ang_nxt = r_sgn[ang_width_p-1:0];
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE:  if (accept) state_nxt = S_PREP;
            S_PREP:  state_nxt = (sat | zero) ? S_POST : S_ITER;
            S_ITER:  if (cnt_r == ITER_LAST) state_nxt = S_POST;
            S_POST:  state_nxt = S_DONE;
            S_DONE:  if (io.yumi_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= S_IDLE;
        else            state_r <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r <= '0;
            neg_r  <= 1'b0;
            sat_r  <= 1'b0;
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            cnt_r  <= '0;
            ang_r  <= '0;
`ifdef BSG_ACTIVATION_INVERSE_LOGIT_EN
            sel_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: if (accept) begin
                    data_r <= io.data_i;
`ifdef BSG_ACTIVATION_INVERSE_LOGIT_EN
                    sel_r  <= io.tanh_sel_i;
`endif
                end
                S_PREP: begin
                    neg_r <= u[W-1];
                    sat_r <= sat;
                    x_r   <= ONE <<< G;
                    y_r   <= u_abs <<< G;
                    z_r   <= zero ? u_abs : '0;
                    cnt_r <= '0;
                end
                S_ITER: begin
                    x_r   <= x_nxt;
                    y_r   <= y_nxt;
                    z_r   <= z_nxt;
                    cnt_r <= cnt_r + 5'd1;
                end
                S_POST: begin
                    ang_r <= ang_nxt;
                    cnt_r <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_activation_inverse.sv
// Bench for bsg_activation_inverse: model-derived expectations queued at accept, checked when v_o rises.
module tb_bsg_activation_inverse;
    localparam int     AW   = 32;
    localparam int     GW   = 21;
    localparam longint MAXV = (64'sd1 <<< (GW-1)) - 1;
`ifdef BSG_ACTIVATION_INVERSE_LOGIT_EN
    localparam bit LOGIT_EN = 1'b1;
`else
    localparam bit LOGIT_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] state;
    int         n_checks = 0;
    int         n_pass   = 0;

    logic [GW-1:0] exp_q[$];
    int            tol_q[$];
    int            lat_q[$];

    logic [AW-1:0] vec_d [14] = '{32'h00008000, 32'hFFFF8000, 32'h0000C000, 32'h0000E666,
                                  32'h00000010, 32'h80000000, 32'h00010000, 32'h0000C000,
                                  32'h0000C001, 32'h00000014, 32'h00000013, 32'h00008000,
                                  32'h80000000, 32'h00000000};
    logic          vec_s [14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    bsg_activation_inverse_if #(.ans_width_p(AW), .ang_width_p(GW)) io();

    bsg_activation_inverse dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .io        (io),
        .state_o   (state)
    );

    always #5 clk = ~clk;

    // Reference: exact fixed-point thresholds, ideal real-valued atanh/logit.
    task automatic model(input logic [AW-1:0] d, input logic s,
                         output logic [GW-1:0] e, output int tol, output int lat);
        longint u, au, r;
        real    a, z;
        logic   logit;
        logit = s & LOGIT_EN;
        u = longint'($signed(d));
        if (logit) u = 2 * u - 65536;
        au = (u < 0) ? -u : u;
        if (au > 49152) begin
            r = MAXV; tol = 0; lat = 2;
        end else if (au < 20) begin
            r = logit ? 2 * au : au; tol = 0; lat = 2;
        end else begin
            a = real'(au) / 65536.0;
            z = 0.5 * $ln((1.0 + a) / (1.0 - a));
            if (logit) z = 2.0 * z;
            r = longint'($rtoi(z * 65536.0 + 0.5));
            tol = logit ? 8 : 4;
            lat = 20;
        end
        if (u < 0) r = -r;
        e = r[GW-1:0];
    endtask

    task automatic send_input(input logic [AW-1:0] d, input logic s, output bit timed_out);
        logic [GW-1:0] e;
        int tol, lat, n;
        @(negedge clk);
        io.v_i = 1'b1; io.data_i = d; io.tanh_sel_i = s;
        n = 0;
        while (!io.ready_and_o && n < 50) begin @(negedge clk); n++; end
        timed_out = !io.ready_and_o;
        @(posedge clk); #1;
        io.v_i = 1'b0;
        model(d, s, e, tol, lat);
        exp_q.push_back(e); tol_q.push_back(tol); lat_q.push_back(lat);
    endtask

    task automatic wait_result(output logic [GW-1:0] got, output int lat);
        lat = 0;
        while (!io.v_o && lat < 100) begin @(posedge clk); #1; lat++; end
        got = io.ang_o;
    endtask

    task automatic take_result;
        if (io.v_o) begin
            @(negedge clk); io.yumi_i = 1'b1;
            @(posedge clk); #1; io.yumi_i = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0; #1;
        n_checks++; if (io.v_o !== 1'b0) $display("FAIL reset v_o: got %b want 0", io.v_o); else n_pass++;
        n_checks++; if (io.ready_and_o !== 1'b0) $display("FAIL reset ready: got %b want 0", io.ready_and_o); else n_pass++;
        n_checks++; if (io.ang_o !== '0) $display("FAIL reset ang_o: got %h want 0", io.ang_o); else n_pass++;
        n_checks++; if (state !== 3'd0) $display("FAIL reset state: got %0d want 0", state); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        n_checks++; if (io.ready_and_o !== 1'b1) $display("FAIL release ready: got %b want 1", io.ready_and_o); else n_pass++;
    endtask

    task automatic test_vectors;
        logic [GW-1:0] got, e;
        int lat, tol, el;
        longint diff;
        bit to;
        for (int i = 0; i < 14; i++) begin
            send_input(vec_d[i], vec_s[i], to);
            wait_result(got, lat);
            e = exp_q.pop_front(); tol = tol_q.pop_front(); el = lat_q.pop_front();
            diff = longint'($signed(got)) - longint'($signed(e));
            n_checks++;
            if (to || diff > tol || diff < -tol)
                $display("FAIL vec%0d value: got %h want %h +/-%0d", i, got, e, tol);
            else n_pass++;
            n_checks++;
            if (lat != el) $display("FAIL vec%0d latency: got %0d want %0d", i, lat, el); else n_pass++;
            take_result();
        end
    endtask

    task automatic test_back_to_back;
        logic [GW-1:0] got, e;
        logic [AW-1:0] d;
        int lat, tol, el;
        longint diff;
        bit to;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) d = AW'($urandom_range(0, 98304)) - AW'(49152);
            else            d = AW'($urandom_range(32'h2000, 32'hE000));
            send_input(d, (i % 2 == 0), to);
            wait_result(got, lat);
            e = exp_q.pop_front(); tol = tol_q.pop_front(); el = lat_q.pop_front();
            diff = longint'($signed(got)) - longint'($signed(e));
            n_checks++;
            if (to || diff > tol || diff < -tol)
                $display("FAIL rnd%0d value: data %h got %h want %h +/-%0d", i, d, got, e, tol);
            else n_pass++;
            n_checks++;
            if (lat != el) $display("FAIL rnd%0d latency: got %0d want %0d", i, lat, el); else n_pass++;
            take_result();
        end
    endtask

    task automatic test_hold;
        logic [GW-1:0] got, e;
        int lat, tol, el;
        bit to;
        send_input(32'h0000E666, 1'b1, to);
        wait_result(got, lat);
        e = exp_q.pop_front(); tol = tol_q.pop_front(); el = lat_q.pop_front();
        n_checks++; if (to || got !== e) $display("FAIL hold first value: got %h want %h", got, e); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++; if (io.ang_o !== e) $display("FAIL hold%0d ang_o: got %h want %h", c, io.ang_o, e); else n_pass++;
            n_checks++; if (io.v_o !== 1'b1) $display("FAIL hold%0d v_o: got %b want 1", c, io.v_o); else n_pass++;
            n_checks++; if (io.ready_and_o !== 1'b0) $display("FAIL hold%0d ready: got %b want 0", c, io.ready_and_o); else n_pass++;
        end
        take_result();
        n_checks++; if (io.v_o !== 1'b0) $display("FAIL after yumi v_o: got %b want 0", io.v_o); else n_pass++;
        n_checks++; if (io.ready_and_o !== 1'b1) $display("FAIL after yumi ready: got %b want 1", io.ready_and_o); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [GW-1:0] got, e;
        int lat, tol, el;
        bit to;
        send_input(32'h0000C000, 1'b1, to);
        exp_q.delete(); tol_q.delete(); lat_q.delete();
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (state !== 3'd2) $display("FAIL mid state before reset: got %0d want 2", state); else n_pass++;
        #2 rst_n = 1'b0; #1;
        n_checks++; if (io.v_o !== 1'b0) $display("FAIL mid reset v_o: got %b want 0", io.v_o); else n_pass++;
        n_checks++; if (io.ready_and_o !== 1'b0) $display("FAIL mid reset ready: got %b want 0", io.ready_and_o); else n_pass++;
        n_checks++; if (io.ang_o !== '0) $display("FAIL mid reset ang_o: got %h want 0", io.ang_o); else n_pass++;
        n_checks++; if (state !== 3'd0) $display("FAIL mid reset state: got %0d want 0", state); else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; io.v_i = 1'b1; io.data_i = 32'hFFFF8000; io.tanh_sel_i = 1'b1;
        @(posedge clk); #1;
        io.v_i = 1'b0;
        n_checks++; if (state !== 3'd1) $display("FAIL first accept after release: state %0d want 1", state); else n_pass++;
        model(32'hFFFF8000, 1'b1, e, tol, el);
        exp_q.push_back(e); tol_q.push_back(tol); lat_q.push_back(el);
        wait_result(got, lat);
        e = exp_q.pop_front(); tol = tol_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (longint'($signed(got)) - longint'($signed(e)) > tol || longint'($signed(e)) - longint'($signed(got)) > tol)
            $display("FAIL post reset value: got %h want %h +/-%0d", got, e, tol);
        else n_pass++;
        n_checks++; if (lat != el) $display("FAIL post reset latency: got %0d want %0d", lat, el); else n_pass++;
        take_result();
    endtask

    initial begin
        io.v_i = 1'b0; io.data_i = '0; io.tanh_sel_i = 1'b0; io.yumi_i = 1'b0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
